// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the oversampling UART receiver.
// Also holds the helper that maps a requested frame width onto a supported one.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    PARITY   = 3'd3,
    STOP1    = 3'd4,
    STOP2    = 3'd5,
    BRK_WAIT = 3'd6
  } rx_state_t;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;
  localparam int DEFAULT_BITS  = 8;

  // Unsupported widths fall back to the default, clipped to what rx_data can hold.
  function automatic logic [3:0] eff_bits(input logic [3:0] req, input int max_bits);
    int lim;
    lim = (max_bits < DATA_BITS_MAX) ? max_bits : DATA_BITS_MAX;
    if (int'(req) >= DATA_BITS_MIN && int'(req) <= lim) return req;
    else if (DEFAULT_BITS <= lim) return 4'(DEFAULT_BITS);
    else return 4'(lim);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Pointer-based receive FIFO with a registered head word.
// A push and a pop in the same clk both succeed even when full.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr, rd_next, wr_next;
  logic [CW-1:0]    count_next;
  logic [WIDTH-1:0] head_next;
  logic             empty, push_ok, pop_ok;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;

  // The head is pre-computed so rx_data is a flop, bypassing a word written this clk.
  always_comb begin
    rd_next    = pop_ok  ? inc(rd_ptr) : rd_ptr;
    wr_next    = push_ok ? inc(wr_ptr) : wr_ptr;
    count_next = count;
    if (push_ok && !pop_ok)      count_next = count + CW'(1);
    else if (pop_ok && !push_ok) count_next = count - CW'(1);
    if (count_next == '0)                    head_next = '0;
    else if (push_ok && rd_next == wr_ptr)   head_next = wdata;
    else                                     head_next = mem[rd_next];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      rd_ptr <= rd_next;
      wr_ptr <= wr_next;
      count  <= count_next;
      head   <= head_next;
    end
  end

endmodule

// File: rtl/uart_rx_async_gen2.sv
// Oversampling UART receiver: synchroniser, 3-sample majority filter, deframer
// with parity/stop/break checking, sticky error flags and a receive FIFO.
module uart_rx_async_gen2
  import uart_rx_pkg::*;
#(
  parameter int DATA_W_MAX = 9,
  parameter int OVS        = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          baud_clock,
  input  logic                          rx,
  input  logic [3:0]                    data_bits,
  input  logic                          parity_en,
  input  logic                          odd_n_even,
  input  logic                          stop2,
  input  logic                          read_rx_byte,
  input  logic                          clear_errors,
  output logic [DATA_W_MAX-1:0]         rx_data,
  output logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          parity_err,
  output logic                          framing_err,
  output logic                          overflow,
  output logic                          break_det,
  output logic                          rx_idle,
  output logic [2:0]                    dbg_state
);

  localparam int CW = $clog2(OVS);

  // Handshake: rx_ready is the valid for rx_data; read_rx_byte is a one-clk pop
  // strobe, ignored when rx_ready is low.

  logic                  sync1, sync2;
  logic [2:0]            filt;
  logic                  rx_f, rx_f_prev;
  rx_state_t             state;
  logic [CW-1:0]         cnt;
  logic [3:0]            bit_idx, nbits;
  logic                  par_en_l, odd_l, stop2_l;
  logic [DATA_W_MAX-1:0] shreg;
  logic                  par_bit, stop1_bit, perr, ferr;
  logic                  last_sample, frame_end, end_stop1, end_ferr, is_break;
  logic                  push, drop, fifo_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      filt      <= 3'b111;
      rx_f_prev <= 1'b1;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
      if (baud_clock) begin
        filt      <= {filt[1:0], sync2};
        rx_f_prev <= rx_f;
      end
    end
  end

  assign rx_f        = (filt[0] & filt[1]) | (filt[1] & filt[2]) | (filt[0] & filt[2]);
  assign last_sample = (cnt == CW'(OVS - 1));

  // Frame-end decisions use the stop sample being taken in this very clk.
  always_comb begin
    frame_end = 1'b0;
    end_stop1 = stop1_bit;
    end_ferr  = ferr;
    if (baud_clock && last_sample) begin
      if (state == STOP1 && !stop2_l) begin
        frame_end = 1'b1;
        end_stop1 = rx_f;
        end_ferr  = ferr | ~rx_f;
      end else if (state == STOP2) begin
        frame_end = 1'b1;
        end_ferr  = ferr | ~rx_f;
      end
    end
    is_break = (shreg == '0) && !(par_en_l && par_bit) && !end_stop1;
  end

  assign push = frame_end & ~is_break;
  assign drop = push & fifo_full & ~read_rx_byte;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      nbits     <= 4'(DEFAULT_BITS);
      par_en_l  <= 1'b0;
      odd_l     <= 1'b0;
      stop2_l   <= 1'b0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      stop1_bit <= 1'b1;
      perr      <= 1'b0;
      ferr      <= 1'b0;
    end else if (baud_clock) begin
      case (state)
        IDLE: begin
          if (rx_f_prev && !rx_f) begin
            state     <= START;
            cnt       <= '0;
            bit_idx   <= '0;
            nbits     <= eff_bits(data_bits, DATA_W_MAX);
            par_en_l  <= parity_en;
            odd_l     <= odd_n_even;
            stop2_l   <= stop2;
            shreg     <= '0;
            par_bit   <= 1'b0;
            stop1_bit <= 1'b1;
            perr      <= 1'b0;
            ferr      <= 1'b0;
          end
        end
        START: begin
          if (cnt == CW'(OVS / 2 - 1)) begin
            cnt   <= '0;
            state <= rx_f ? IDLE : DATA;
          end else cnt <= cnt + CW'(1);
        end
        DATA: begin
          if (last_sample) begin
            shreg[bit_idx] <= rx_f;
            cnt            <= '0;
            bit_idx        <= bit_idx + 4'd1;
            if (bit_idx == nbits - 4'd1) state <= par_en_l ? PARITY : STOP1;
          end else cnt <= cnt + CW'(1);
        end
        PARITY: begin
          if (last_sample) begin
            par_bit <= rx_f;
            perr    <= ((^shreg) ^ rx_f) != odd_l;
            cnt     <= '0;
            state   <= STOP1;
          end else cnt <= cnt + CW'(1);
        end
        STOP1: begin
          if (last_sample) begin
            stop1_bit <= rx_f;
            ferr      <= ferr | ~rx_f;
            cnt       <= '0;
            if (stop2_l)       state <= STOP2;
            else if (is_break) state <= BRK_WAIT;
            else               state <= IDLE;
          end else cnt <= cnt + CW'(1);
        end
        STOP2: begin
          if (last_sample) begin
            cnt   <= '0;
            state <= is_break ? BRK_WAIT : IDLE;
          end else cnt <= cnt + CW'(1);
        end
        BRK_WAIT: begin
          if (rx_f) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky flags: a set in the same clk as clear_errors wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      overflow    <= 1'b0;
      break_det   <= 1'b0;
    end else begin
      parity_err  <= (push & perr)     | (parity_err  & ~clear_errors);
      framing_err <= (push & end_ferr) | (framing_err & ~clear_errors);
      overflow    <= drop              | (overflow    & ~clear_errors);
      break_det   <= (frame_end & is_break) | (break_det & ~clear_errors);
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W_MAX)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (shreg),
    .pop     (read_rx_byte),
    .head    (rx_data),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign rx_ready  = (fifo_count != '0);
  assign rx_idle   = (state == IDLE);
  assign dbg_state = state;

endmodule
